// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-port memory responder.
// Access-size encoding, FSM states and the alignment/legality rule.
package data_mem_pkg;

   typedef enum logic [2:0] {
      SZ_B  = 3'd0,
      SZ_H  = 3'd1,
      SZ_W  = 3'd2,
      SZ_BU = 3'd4,
      SZ_HU = 3'd5
   } size_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   // Undefined size codes count as misaligned so one flag covers every error.
   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr);
      case (size)
         SZ_B, SZ_BU: return 1'b0;
         SZ_H, SZ_HU: return addr[0];
         SZ_W:        return (addr != 2'b00);
         default:     return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the core's right-aligned data and the RAM word:
// store byte-enables and replicated write data, load extraction and extension.
module mem_lane_align
   import data_mem_pkg::*;
(
   input  logic [2:0]  i_size,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_rword,
   input  logic [31:0] i_wdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wword,
   output logic [31:0] o_ldata,
   output logic        o_err
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign o_err  = is_misaligned(i_size, i_addr);
   assign w_byte = i_rword[{i_addr, 3'b000} +: 8];
   assign w_half = i_addr[1] ? i_rword[31:16] : i_rword[15:0];

   // Write data is replicated across lanes; the byte-enable picks the live ones.
   always_comb begin
      o_be    = 4'b0000;
      o_wword = i_wdata;
      o_ldata = 32'h0;
      if (!o_err) begin
         case (i_size)
            SZ_B, SZ_BU: begin
               o_be    = 4'b0001 << i_addr;
               o_wword = {4{i_wdata[7:0]}};
               o_ldata = (i_size == SZ_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            end
            SZ_H, SZ_HU: begin
               o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
               o_wword = {2{i_wdata[15:0]}};
               o_ldata = (i_size == SZ_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            end
            SZ_W: begin
               o_be    = 4'b1111;
               o_ldata = i_rword;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency responder for the core data port: stalls the core LATENCY
// cycles, then commits the access to the word RAM and presents one RESP cycle.
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int WORDS     = 1024,
   parameter int LATENCY   = 2,
   parameter     INIT_FILE = ""
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [2:0]  size_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        err_o
);

   localparam int AW = $clog2(WORDS);

   state_e        r_state, w_next;
   logic [3:0]    r_cnt, w_cnt_nxt;
   logic [31:0]   r_rdata;
   logic          r_err;
   logic          w_commit;
   logic          w_wr;
   logic [AW-1:0] w_idx;
   logic [3:0]    w_be;
   logic [31:0]   w_wword, w_ldata;
   logic          w_err;
   logic          w_unused;

   logic [31:0]   r_mem [WORDS];

   assign w_idx    = addr_i[AW+1:2];
   assign w_unused = ^addr_i[31:AW+2];

   mem_lane_align u_align (
      .i_size  (size_i),
      .i_addr  (addr_i[1:0]),
      .i_rword (r_mem[w_idx]),
      .i_wdata (wdata_i),
      .o_be    (w_be),
      .o_wword (w_wword),
      .o_ldata (w_ldata),
      .o_err   (w_err)
   );

   // w_commit marks the edge that enters RESP; all side effects happen there.
   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      w_commit  = 1'b0;
      case (r_state)
         IDLE: if (req_i) begin
            w_cnt_nxt = 4'(LATENCY - 1);
            if (LATENCY == 1) begin
               w_next   = RESP;
               w_commit = 1'b1;
            end else begin
               w_next = WAIT;
            end
         end
         WAIT: if (!req_i) begin
            w_next = IDLE;
         end else begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_next   = RESP;
               w_commit = 1'b1;
            end
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_rdata <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_commit && w_err;
         if (w_commit)
            r_rdata <= (we_i || w_err) ? 32'h0 : w_ldata;
      end
   end

   // Reset can coincide with a single-cycle commit from IDLE; never write then.
   assign w_wr = w_commit && we_i && !w_err && !rst_i;

   always_ff @(posedge clk_i) begin
      if (w_wr) begin
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
   end

   assign rdata_o = r_rdata;
   assign err_o   = r_err;
   assign stall_o = req_i && (r_state != RESP);

   a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (r_state == WAIT && req_i) |-> $stable({we_i, size_i, addr_i, wdata_i}));

endmodule
